bpu_update_ctrl: RTL

Branch-predictor update controller for the BPU: the writer side of the pattern history table. It forms the gshare lookup index at fetch and keeps a speculative global history register (GHR). It buffers each in-flight prediction in an in-order queue and, when the branch resolves in execute, drives the registered PHT counter update. On a misprediction it raises a recovery pulse, repairs the GHR and flushes all younger wrong-path entries.

---
 rtl/bpu_update_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bpu_update_ctrl.sv
// gshare PHT update controller: forms the lookup index, keeps the speculative GHR,
// queues in-flight predictions in order and drives registered PHT training / recovery.
module bpu_update_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int PC_WIDTH   = 64,
    parameter int DEPTH      = 8
) (
    input  logic                      in_Clk,
    input  logic                      in_Rst,
    input  logic                      in_pred_valid,
    input  logic [PC_WIDTH-1:0]       in_pred_pc,
    input  logic                      in_pred_taken,
    output logic                      out_pred_ready,
    output logic [ADDR_WIDTH-1:0]     out_lookup_addr,
    input  logic                      in_resolve_valid,
    input  logic                      in_resolve_taken,
    output logic                      out_pht_en,
    output logic [ADDR_WIDTH-1:0]     out_pht_addr,
    output logic                      out_pht_data,
    output logic                      out_mispredict,
    output logic [ADDR_WIDTH-1:0]     out_ghr,
    output logic [$clog2(DEPTH):0]    out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] idx_mem_q  [DEPTH];
    logic                  pred_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] snap_mem_q [DEPTH];

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] ghr_q, ghr_d;
    logic                  pht_en_q, pht_en_d;
    logic [ADDR_WIDTH-1:0] pht_addr_q, pht_addr_d;
    logic                  pht_data_q, pht_data_d;
    logic                  mispredict_q, mispredict_d;

    logic                  push, pop, mis;
    logic                  unused_pc;

    assign unused_pc = ^{in_pred_pc[PC_WIDTH-1:ADDR_WIDTH+2], in_pred_pc[1:0]};

    assign out_lookup_addr = in_pred_pc[ADDR_WIDTH+1:2] ^ ghr_q;
    assign out_pred_ready  = (count_q < CNT_W'(DEPTH));

    assign push = in_pred_valid && out_pred_ready;
    assign pop  = in_resolve_valid && (count_q != '0);
    assign mis  = pop && (pred_mem_q[rd_ptr_q] != in_resolve_taken);

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ghr_d        = ghr_q;
        pht_en_d     = pop;
        pht_addr_d   = pht_addr_q;
        pht_data_d   = pht_data_q;
        mispredict_d = mis;

        if (pop) begin
            pht_addr_d = idx_mem_q[rd_ptr_q];
            pht_data_d = in_resolve_taken;
        end

        // A mispredict discards any same-cycle push: repair from the head snapshot and flush.
        if (mis) begin
            ghr_d    = {snap_mem_q[rd_ptr_q][ADDR_WIDTH-2:0], in_resolve_taken};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                ghr_d    = {ghr_q[ADDR_WIDTH-2:0], in_pred_taken};
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ghr_q        <= '0;
            pht_en_q     <= 1'b0;
            pht_addr_q   <= '0;
            pht_data_q   <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ghr_q        <= ghr_d;
            pht_en_q     <= pht_en_d;
            pht_addr_q   <= pht_addr_d;
            pht_data_q   <= pht_data_d;
            mispredict_q <= mispredict_d;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Rst && push && !mis) begin
            idx_mem_q[wr_ptr_q]  <= out_lookup_addr;
            pred_mem_q[wr_ptr_q] <= in_pred_taken;
            snap_mem_q[wr_ptr_q] <= ghr_q;
        end
    end

    assign out_pht_en     = pht_en_q;
    assign out_pht_addr   = pht_addr_q;
    assign out_pht_data   = pht_data_q;
    assign out_mispredict = mispredict_q;
    assign out_ghr        = ghr_q;
    assign out_count      = count_q;

endmodule
